mix_columns_engine: RTL and testbench
=====================================

# mix_columns_engine

Sequential, parametrised AES MixColumns / InvMixColumns unit operating on a full 128-bit state. It accepts one state over a valid/ready handshake, processes LANES columns per clock, and holds the result until the consumer takes it. It sits between ShiftRows and AddRoundKey in the round datapath. It replaces per-word combinational mixing with a shared, area-scalable engine that also supports decryption.

## Interface
- LANES, default 4: columns processed per cycle; legal values 1, 2, 4; any other value is an elaboration error.
- INV_EN, default 1: 1 builds the inverse path; 0 means forward only and in_inv is ignored (treated as 0).
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_state/in_inv are valid.
- in_ready  output  1  engine can accept a state.
- in_state  input  128  state; column c = bits [127-32c : 96-32c]; within a column, row 0 is the top byte [31:24].
- in_inv  input  1  1 = InvMixColumns, 0 = MixColumns; sampled on acceptance.
- out_valid  output  1  out_state holds a finished result.
- out_ready  input  1  consumer accepts the result.
- out_state  output  128  result, same layout as in_state.
- busy  output  1  high whenever state ≠ IDLE.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&in_ready:
  - latch in_state into the working register;
  - latch the mode (in_inv & INV_EN);
  - clear the column counter cnt (2 bits);
  - go to RUN.
- RUN: each cycle, columns cnt..cnt+LANES-1 are replaced in place by their mixed value, then cnt += LANES.
  - When the last group is written (cnt+LANES = 4), go to DONE.
  - Groups are processed in column order 0→3.
- DONE: out_valid=1 and out_state = working register. On out_ready, go to IDLE.
  - out_state must stay stable while out_valid=1 and out_ready=0.
- Forward column math, per column (a0..a3) → (b0..b3), where xt = GF(2^8) multiply by 2 (shift left, XOR 0x1B if the MSB was set):
  - b0 = xt(a0)^xt(a1)^a1^a2^a3
  - b1 = a0^xt(a1)^xt(a2)^a2^a3
  - b2 = a0^a1^xt(a2)^xt(a3)^a3
  - b3 = xt(a0)^a0^a1^a2^xt(a3)
- Inverse (mode=1): pre-condition the column, then apply the forward math. This equals the matrix {0e,0b,0d,09}.
  - u = xt(xt(a0^a2)), v = xt(xt(a1^a3))
  - a0^=u, a1^=v, a2^=u, a3^=v
- LANES column-mix instances are shared across cycles. The pre-conditioner is muxed in only when mode=1. No other arithmetic is allowed; all byte ops are 8-bit XOR, with no carries.

## Timing
- Reset (rst=1 at an edge), regardless of state:
  - state→IDLE, cnt→0, mode→0, working register→0;
  - in_ready=1 from the following cycle; out_valid=0, out_state=0, busy=0.
  - An in-flight state is discarded; no partial output ever appears.
- in_ready is a decode of state only and must not depend combinationally on in_valid, out_ready or any other input.
- Latency: acceptance at edge E0 → out_valid high after edge E(4/LANES).
  - LANES=4: 1 cycle; LANES=2: 2 cycles; LANES=1: 4 cycles.
- Throughput: one state per 4/LANES+2 cycles with out_ready held high (accept, RUN cycles, DONE handoff).
- in_valid during RUN/DONE is ignored, not queued. The producer must hold it until in_ready.
- out_ready while out_valid=0 has no effect.
- in_inv changes after acceptance have no effect on the current state.

## Test plan
- Forward, all LANES values: columns db135345, f20a225c, 01010101, c6c6c6c6 → 8e4da1bc, 9fdc589d, 01010101, c6c6c6c6. out_valid must rise exactly 1/2/4 cycles after acceptance.
- Inverse (INV_EN=1, in_inv=1): input 8e4da1bc 9fdc589d d5d5d7d6 4d7ebdf8 → db135345 f20a225c d4d4d4d5 2d26314c. Also check that forward then inverse on a random state round-trips, over 1000 random states.
- Backpressure: hold out_ready=0 for 10 cycles in DONE. Require out_state stable, in_ready=0, and a second in_valid not accepted; release out_ready, then IDLE the next cycle.
- Reset mid-RUN with LANES=1: assert rst after 2 RUN cycles. Next cycle: out_valid=0, out_state=0, in_ready=1, busy=0. The next accepted state yields a correct, uncorrupted result.
- INV_EN=0: in_inv=1 with d4d4d4d5 in every column → d5d5d7d6 (forward result).
- Back-to-back stream of 8 states, in_valid and out_ready held high: results in order, one per 4/LANES+2 cycles, none dropped or duplicated.

Source files
------------

// File: rtl/mix_columns_engine.sv
// AES MixColumns / InvMixColumns engine for a full 128-bit state.
// It mixes LANES columns per clock in place and holds the result until the consumer takes it.
module mix_columns_engine #(
  parameter int LANES  = 4,
  parameter int INV_EN = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy,
  output logic [1:0]   dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // ready is a pure state decode, and the producer holds valid and data until it is accepted.

  if (LANES != 1 && LANES != 2 && LANES != 4) begin : g_lanes_check
    $error("mix_columns_engine: LANES must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state, next_state;
  logic [127:0] work, next_work;
  logic [1:0]   cnt;
  logic         mode;
  logic         last_grp;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // The inverse matrix factors as the forward matrix times a cheap pre-conditioner.
  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
    logic [7:0] a0, a1, a2, a3, u, v;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    if (inv) begin
      u  = xt(xt(a0 ^ a2));
      v  = xt(xt(a1 ^ a3));
      a0 = a0 ^ u;
      a1 = a1 ^ v;
      a2 = a2 ^ u;
      a3 = a3 ^ v;
    end
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  // One mixer per lane; cnt steers each lane to its column in the working register.
  always_comb begin
    next_work = work;
    for (int l = 0; l < LANES; l++) begin
      int c;
      c = int'(cnt) + l;
      next_work[127-32*c -: 32] = mix_col(work[127-32*c -: 32], mode);
    end
  end

  assign last_grp = (int'(cnt) + LANES) == 4;

  always_comb begin
    next_state = state;
    in_ready   = (state == IDLE);
    out_valid  = (state == DONE);
    busy       = (state != IDLE);
    case (state)
      IDLE:    if (in_valid) next_state = RUN;
      RUN:     if (last_grp) next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 2'd0;
      mode  <= 1'b0;
      work  <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: if (in_valid) begin
          work <= in_state;
          mode <= in_inv & (INV_EN != 0);
          cnt  <= 2'd0;
        end
        RUN: begin
          work <= next_work;
          cnt  <= cnt + 2'(LANES);
        end
        default: ;
      endcase
    end
  end

  // Partial results in RUN are never exposed.
  assign out_state = (state == DONE) ? work : '0;
  assign dbg_state = state;

endmodule

// File: tb/tb_mix_columns_engine.sv
// Bench for mix_columns_engine: four instances (LANES 4/2/1 with inverse, LANES 4 forward only)
// checked against a GF(2^8) matrix model through a per-instance expected queue.
module tb_mix_columns_engine;

  localparam logic [127:0] FWD_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] FWD_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] INV_IN  = 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8;
  localparam logic [127:0] INV_OUT = 128'hdb135345_f20a225c_d4d4d4d5_2d26314c;
  localparam logic [127:0] IE0_IN  = {4{32'hd4d4d4d5}};
  localparam logic [127:0] IE0_OUT = {4{32'hd5d5d7d6}};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid [4];
  logic         in_ready [4];
  logic [127:0] in_state [4];
  logic         in_inv   [4];
  logic         out_valid[4];
  logic         out_ready[4];
  logic [127:0] out_state[4];
  logic         busy     [4];
  logic [1:0]   dbg_state[4];

  logic [127:0] exp_q[4][$];
  int           hs_q[4][$];
  logic [127:0] last_out[4];
  logic         held[4];
  logic [127:0] held_val[4];
  logic [127:0] mon_e;
  int           cyc = 0;
  int           checks = 0;
  int           errors = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    mix_columns_engine #(
      .LANES (g == 0 ? 4 : g == 1 ? 2 : g == 2 ? 1 : 4),
      .INV_EN(g == 3 ? 0 : 1)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .in_state (in_state[g]),
      .in_inv   (in_inv[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .out_state(out_state[g]),
      .busy     (busy[g]),
      .dbg_state(dbg_state[g])
    );
  end

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- model ----------------
  function automatic int lanes_of(int k);
    return (k == 0) ? 4 : (k == 1) ? 2 : (k == 2) ? 1 : 4;
  endfunction

  function automatic bit inv_en_of(int k);
    return k != 3;
  endfunction

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] model(logic [127:0] st, bit inv);
    logic [7:0]   m[4];
    logic [7:0]   a[4];
    logic [7:0]   b;
    logic [127:0] r = '0;
    if (inv) m = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     m = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) a[j] = st[127-32*c-8*j -: 8];
      for (int row = 0; row < 4; row++) begin
        b = 8'h00;
        for (int j = 0; j < 4; j++) b ^= gmul(a[j], m[(j - row + 4) % 4]);
        r[127-32*c-8*row -: 8] = b;
      end
    end
    return r;
  endfunction

  task automatic chk(string name, logic [127:0] got, logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // Presents a state and returns #1 after the accepting edge; the expected result is queued then.
  task automatic offer(int k, logic [127:0] st, logic inv, bit drop);
    int n = 0;
    in_state[k] = st;
    in_inv[k]   = inv;
    in_valid[k] = 1'b1;
    @(negedge clk);
    while (!in_ready[k] && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready[k]) begin
      checks++; errors++;
      $display("FAIL accept_timeout dut%0d: got in_ready=0 expected 1", k);
      in_valid[k] = 1'b0;
      return;
    end
    @(posedge clk);
    exp_q[k].push_back(model(st, bit'(inv) && inv_en_of(k)));
    #1;
    if (drop) in_valid[k] = 1'b0;
  endtask

  // Called #1 after acceptance; checks latency, then waits past the next edge.
  task automatic wait_done(int k);
    int n = 0;
    @(negedge clk);
    while (!out_valid[k] && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (!out_valid[k]) begin
      checks++; errors++;
      $display("FAIL done_timeout dut%0d: got out_valid=0 expected 1", k);
    end else begin
      chk($sformatf("latency_dut%0d", k), 128'(n), 128'(4 / lanes_of(k)));
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (!rst && out_valid[k]) begin
        if (held[k]) chk($sformatf("hold_stable_dut%0d", k), out_state[k], held_val[k]);
        if (out_ready[k]) begin
          if (exp_q[k].size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_output dut%0d: got %h expected none", k, out_state[k]);
          end else begin
            mon_e = exp_q[k].pop_front();
            chk($sformatf("result_dut%0d", k), out_state[k], mon_e);
          end
          last_out[k] = out_state[k];
          hs_q[k].push_back(cyc);
          held[k] = 1'b0;
        end else begin
          held[k]     = 1'b1;
          held_val[k] = out_state[k];
        end
      end else begin
        held[k] = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [127:0] st, r;
    logic [127:0] bp_val;
    for (int k = 0; k < 4; k++) begin
      in_valid[k] = 1'b0; in_state[k] = '0; in_inv[k] = 1'b0;
      out_ready[k] = 1'b1; held[k] = 1'b0; last_out[k] = '0;
    end

    // model pinned to hand values
    chk("model_fwd", model(FWD_IN, 1'b0), FWD_OUT);
    chk("model_inv", model(INV_IN, 1'b1), INV_OUT);
    chk("model_d4", model(IE0_IN, 1'b0), IE0_OUT);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_in_ready_dut%0d", k), 128'(in_ready[k]), 128'(1));
      chk($sformatf("rst_out_valid_dut%0d", k), 128'(out_valid[k]), 128'(0));
      chk($sformatf("rst_out_state_dut%0d", k), out_state[k], '0);
      chk($sformatf("rst_busy_dut%0d", k), 128'(busy[k]), 128'(0));
    end
    @(posedge clk); #1;

    // directed vectors
    for (int k = 0; k < 4; k++) begin
      offer(k, FWD_IN, 1'b0, 1'b1); wait_done(k);
      chk($sformatf("fwd_vec_dut%0d", k), last_out[k], FWD_OUT);
    end
    for (int k = 0; k < 3; k++) begin
      offer(k, INV_IN, 1'b1, 1'b1); wait_done(k);
      chk($sformatf("inv_vec_dut%0d", k), last_out[k], INV_OUT);
    end
    offer(3, IE0_IN, 1'b1, 1'b1); wait_done(3);
    chk("inv_disabled_dut3", last_out[3], IE0_OUT);

    // in_inv flipped right after acceptance must not change the mode
    offer(1, FWD_IN, 1'b0, 1'b1); in_inv[1] = 1'b1; wait_done(1);

    // random round trips
    for (int i = 0; i < 1002; i++) begin
      int k = i % 3;
      st = {$urandom, $urandom, $urandom, $urandom};
      offer(k, st, 1'b0, 1'b1); wait_done(k);
      r = last_out[k];
      offer(k, r, 1'b1, 1'b1); wait_done(k);
      if (i % 50 == 0) chk($sformatf("roundtrip_dut%0d", k), last_out[k], st);
    end
    for (int i = 0; i < 40; i++) begin
      offer(3, {$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b1);
      wait_done(3);
    end

    // backpressure on dut0
    out_ready[0] = 1'b0;
    offer(0, INV_IN, 1'b1, 1'b1); wait_done(0);
    bp_val = FWD_IN;
    in_state[0] = bp_val; in_inv[0] = 1'b0; in_valid[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 128'(in_ready[0]), 128'(0));
      chk("bp_out_valid", 128'(out_valid[0]), 128'(1));
      chk("bp_out_state", out_state[0], INV_OUT);
    end
    in_valid[0] = 1'b0;
    @(posedge clk); #1 out_ready[0] = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("bp_idle_out_valid", 128'(out_valid[0]), 128'(0));
    chk("bp_idle_busy", 128'(busy[0]), 128'(0));
    chk("bp_idle_in_ready", 128'(in_ready[0]), 128'(1));
    chk("bp_no_pending", 128'(exp_q[0].size()), 128'(0));
    @(posedge clk); #1;

    // reset during RUN on the LANES=1 instance
    offer(2, FWD_IN, 1'b0, 1'b1);
    @(posedge clk); @(posedge clk);
    #1 rst = 1'b1;
    exp_q[2].delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 128'(out_valid[2]), 128'(0));
    chk("midrst_out_state", out_state[2], '0);
    chk("midrst_in_ready", 128'(in_ready[2]), 128'(1));
    chk("midrst_busy", 128'(busy[2]), 128'(0));
    @(posedge clk); #1;
    offer(2, INV_IN, 1'b1, 1'b1); wait_done(2);
    chk("midrst_next", last_out[2], INV_OUT);

    // back-to-back stream of 8 states per instance
    for (int k = 0; k < 4; k++) begin
      int n = 0;
      hs_q[k].delete();
      for (int i = 0; i < 8; i++) offer(k, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
      in_valid[k] = 1'b0;
      while (hs_q[k].size() < 8 && n < 100) begin
        n++;
        @(posedge clk);
      end
      #1;
      chk($sformatf("stream_count_dut%0d", k), 128'(hs_q[k].size()), 128'(8));
      for (int i = 1; i < hs_q[k].size(); i++)
        chk($sformatf("stream_gap_dut%0d", k), 128'(hs_q[k][i] - hs_q[k][i-1]), 128'(4 / lanes_of(k) + 2));
      chk($sformatf("stream_drained_dut%0d", k), 128'(exp_q[k].size()), 128'(0));
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
